// File: rtl/max7219_rx.sv
// -----------------------------------------------------------------------------
// max7219_rx
// Receive-side model of a MAX7219 daisy chain. Oversamples DIN/CLK/LOAD on the
// system clock, shifts bits through a chain of N = DISP_ROWS*DISP_COLUMNS
// 16-bit device registers and, on every LOAD rising edge, decodes each
// device's word into that device's register file.
//
// Optional build macro: MAX7219_RX_DOUT_EN -- adds o_Dout, the registered
// far-end chain bit (models the last device's DOUT).
//
// Ports
//   i_Clk          system clock, rising edge
//   i_Rst          asynchronous, active-high reset
//   i_Din/i_Sclk/i_Load   serial link, asynchronous to i_Clk
//   o_Digit        [N-1:0][0:7][7:0] digit rows, row index = address-1
//   o_Intensity    [N-1:0][3:0]  reg 0xA
//   o_Scan_Limit   [N-1:0][2:0]  reg 0xB
//   o_Decode       [N-1:0][7:0]  reg 0x9
//   o_Shutdown     [N-1:0]       1 = shut down (reg 0xC writes ~data[0])
//   o_Test         [N-1:0]       reg 0xF data[0]
//   o_Frame_Valid  one-cycle pulse on every latch
//   o_Frame_Error  coincident pulse when the bit count was not 16*N
//   o_Dout         far-end chain bit (MAX7219_RX_DOUT_EN only)
// -----------------------------------------------------------------------------

// Per-device register file: decodes one 12-bit {addr,data} slice on latch.
module max7219_rx_dev (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             latch_i,
    input  logic [11:0]      word_i,
    output logic [0:7][7:0]  digit_o,
    output logic [3:0]       intensity_o,
    output logic [2:0]       scan_limit_o,
    output logic [7:0]       decode_o,
    output logic             shutdown_o,
    output logic             test_o
);
    logic [3:0] addr;
    logic [7:0] data;

    assign addr = word_i[11:8];
    assign data = word_i[7:0];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            digit_o      <= '0;
            intensity_o  <= '0;
            scan_limit_o <= '0;
            decode_o     <= '0;
            shutdown_o   <= 1'b1;
            test_o       <= 1'b0;
        end else if (latch_i) begin
            case (addr)
                4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8: digit_o[3'(addr - 4'h1)] <= data;
                4'h9:    decode_o     <= data;
                4'hA:    intensity_o  <= data[3:0];
                4'hB:    scan_limit_o <= data[2:0];
                4'hC:    shutdown_o   <= ~data[0];
                4'hF:    test_o       <= data[0];
                default: ;  // 0x0 no-op, 0xD/0xE ignored
            endcase
        end
    end
endmodule

module max7219_rx #(
    parameter int DISP_ROWS    = 1,
    parameter int DISP_COLUMNS = 1
) (
    input  logic                                          i_Clk,
    input  logic                                          i_Rst,
    input  logic                                          i_Din,
    input  logic                                          i_Sclk,
    input  logic                                          i_Load,
    output logic [DISP_ROWS*DISP_COLUMNS-1:0][0:7][7:0]   o_Digit,
    output logic [DISP_ROWS*DISP_COLUMNS-1:0][3:0]        o_Intensity,
    output logic [DISP_ROWS*DISP_COLUMNS-1:0][2:0]        o_Scan_Limit,
    output logic [DISP_ROWS*DISP_COLUMNS-1:0][7:0]        o_Decode,
    output logic [DISP_ROWS*DISP_COLUMNS-1:0]             o_Shutdown,
    output logic [DISP_ROWS*DISP_COLUMNS-1:0]             o_Test,
    output logic                                          o_Frame_Valid,
    output logic                                          o_Frame_Error
`ifdef MAX7219_RX_DOUT_EN
    ,
    output logic                                          o_Dout
`endif
);
    localparam int N        = DISP_ROWS * DISP_COLUMNS;
    localparam int CW       = 16 * N;
    localparam int CNT_W    = $clog2(CW + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CW + 1);

    // [0],[1] synchronizer stages, [2] history for edge detection
    logic [1:0] din_s_q;
    logic [2:0] sclk_s_q;
    logic [2:0] load_s_q;

    logic [CW-1:0]    chain_q, chain_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             vld_q,   err_q;

    logic sclk_rise, load_rise, shift_en, err_d;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            din_s_q  <= '0;
            sclk_s_q <= '0;
            load_s_q <= '0;
        end else begin
            din_s_q  <= {din_s_q[0], i_Din};
            sclk_s_q <= {sclk_s_q[1:0], i_Sclk};
            load_s_q <= {load_s_q[1:0], i_Load};
        end
    end

    assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
    assign load_rise = load_s_q[1] & ~load_s_q[2];
    // Gate on the previous LOAD sample so an SCLK edge coinciding with the
    // LOAD edge still shifts in (the final bit of a frame).
    assign shift_en  = sclk_rise & ~load_s_q[2];

    always_comb begin
        chain_d = chain_q;
        cnt_d   = cnt_q;
        if (shift_en) begin
            chain_d = {chain_q[CW-2:0], din_s_q[1]};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
    end

    // Latch sees the post-shift chain and count.
    assign err_d = load_rise && (cnt_d != CNT_FULL);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            chain_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= load_rise ? '0 : cnt_d;
            vld_q   <= load_rise;
            err_q   <= err_d;
        end
    end

    assign o_Frame_Valid = vld_q;
    assign o_Frame_Error = err_q;

    for (genvar g = 0; g < N; g++) begin : g_dev
        max7219_rx_dev u_dev (
            .i_Clk        (i_Clk),
            .i_Rst        (i_Rst),
            .latch_i      (load_rise),
            .word_i       (chain_d[16*g +: 12]),
            .digit_o      (o_Digit[g]),
            .intensity_o  (o_Intensity[g]),
            .scan_limit_o (o_Scan_Limit[g]),
            .decode_o     (o_Decode[g]),
            .shutdown_o   (o_Shutdown[g]),
            .test_o       (o_Test[g])
        );
    end

`ifdef MAX7219_RX_DOUT_EN
    logic dout_q;
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) dout_q <= 1'b0;
        else       dout_q <= chain_q[CW-1];
    end
    assign o_Dout = dout_q;
`endif
endmodule
